// File: rtl/graphite_pkg.sv
// Shared types and widths for the graphite VRAM path.
package graphite_pkg;

  localparam int VRAM_DATA_W = 16;
  localparam int VRAM_ADDR_W = 32;
  localparam int VRAM_MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_GFX  = 1'b0,
    GRANT_SCAN = 1'b1
  } grant_t;

  // Framebuffer-relative to absolute word address; wraps modulo 2^32.
  function automatic logic [VRAM_ADDR_W-1:0] fb_map(
    input logic [VRAM_ADDR_W-1:0] base,
    input logic [VRAM_ADDR_W-1:0] rel
  );
    return base + rel;
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the rasterizer and display scanout.
// Owns front/back buffer selection and maps relative addresses to absolute.
module vram_arbiter
  import graphite_pkg::*;
#(
  parameter int FB_WIDTH     = 128,
  parameter int FB_HEIGHT    = 128,
  parameter int FB0_BASE     = 0,
  parameter int FB1_BASE     = FB_WIDTH * FB_HEIGHT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   gfx_sel_i,
  input  logic                   gfx_wr_i,
  input  logic [VRAM_MASK_W-1:0] gfx_mask_i,
  input  logic [VRAM_ADDR_W-1:0] gfx_addr_i,
  input  logic [VRAM_DATA_W-1:0] gfx_data_i,
  output logic [VRAM_DATA_W-1:0] gfx_data_o,
  output logic                   gfx_ack_o,
  input  logic                   swap_i,
  input  logic                   scan_req_i,
  input  logic [VRAM_ADDR_W-1:0] scan_addr_i,
  output logic [VRAM_DATA_W-1:0] scan_data_o,
  output logic                   scan_ack_o,
  output logic                   mem_req_o,
  output logic                   mem_wr_o,
  output logic [VRAM_MASK_W-1:0] mem_mask_o,
  output logic [VRAM_ADDR_W-1:0] mem_addr_o,
  output logic [VRAM_DATA_W-1:0] mem_wdata_o,
  input  logic [VRAM_DATA_W-1:0] mem_rdata_i,
  input  logic                   mem_ack_i,
  output logic                   front_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]       STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [VRAM_ADDR_W-1:0] FB0_ADDR   = VRAM_ADDR_W'(FB0_BASE);
  localparam logic [VRAM_ADDR_W-1:0] FB1_ADDR   = VRAM_ADDR_W'(FB1_BASE);

  arb_state_t             state_r;
  grant_t                 grant_r;
  logic [CNT_W-1:0]       starve_cnt_r;
  logic                   front_pending_r;
  logic                   scan_win_s;
  logic                   gfx_win_s;
  logic [VRAM_ADDR_W-1:0] scan_base_s;
  logic [VRAM_ADDR_W-1:0] gfx_base_s;

  // Pick the winner: scan has priority until gfx has waited STARVE_LIMIT scan grants.
  always_comb begin
    scan_win_s = 1'b0;
    gfx_win_s  = 1'b0;
    if (scan_req_i && (!gfx_sel_i || (starve_cnt_r < STARVE_MAX))) begin
      scan_win_s = 1'b1;
    end else if (gfx_sel_i) begin
      gfx_win_s = 1'b1;
    end else begin
      scan_win_s = 1'b0;
      gfx_win_s  = 1'b0;
    end
  end

  // Scanout reads the front buffer, the rasterizer works on the back buffer.
  always_comb begin
    scan_base_s = FB0_ADDR;
    gfx_base_s  = FB1_ADDR;
    if (front_o) begin
      scan_base_s = FB1_ADDR;
      gfx_base_s  = FB0_ADDR;
    end else begin
      scan_base_s = FB0_ADDR;
      gfx_base_s  = FB1_ADDR;
    end
  end

  // Swap pulses toggle a pending bit; it reaches front_o only between transactions.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      front_pending_r <= 1'b0;
    end else if (swap_i) begin
      front_pending_r <= ~front_pending_r;
    end
  end

  // Count consecutive scan grants that made a pending rasterizer wait.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == IDLE) begin
      if (gfx_win_s || !gfx_sel_i) begin
        starve_cnt_r <= {CNT_W{1'b0}};
      end else if (scan_win_s && (starve_cnt_r < STARVE_MAX)) begin
        starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Grant / memory access / ack sequencing with registered outputs.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      grant_r     <= GRANT_GFX;
      mem_req_o   <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_mask_o  <= {VRAM_MASK_W{1'b0}};
      mem_addr_o  <= {VRAM_ADDR_W{1'b0}};
      mem_wdata_o <= {VRAM_DATA_W{1'b0}};
      gfx_data_o  <= {VRAM_DATA_W{1'b0}};
      scan_data_o <= {VRAM_DATA_W{1'b0}};
      gfx_ack_o   <= 1'b0;
      scan_ack_o  <= 1'b0;
      front_o     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // The grant below still uses the old front; the new one applies next time.
          front_o <= front_pending_r;
          if (scan_win_s) begin
            grant_r     <= GRANT_SCAN;
            mem_req_o   <= 1'b1;
            mem_wr_o    <= 1'b0;
            mem_mask_o  <= {VRAM_MASK_W{1'b0}};
            mem_addr_o  <= fb_map(scan_base_s, scan_addr_i);
            mem_wdata_o <= {VRAM_DATA_W{1'b0}};
            state_r     <= BUSY;
          end else if (gfx_win_s) begin
            grant_r     <= GRANT_GFX;
            mem_req_o   <= 1'b1;
            mem_wr_o    <= gfx_wr_i;
            mem_mask_o  <= gfx_mask_i;
            mem_addr_o  <= fb_map(gfx_base_s, gfx_addr_i);
            mem_wdata_o <= gfx_data_i;
            state_r     <= BUSY;
          end else begin
            mem_req_o <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state_r   <= DONE;
            if (grant_r == GRANT_SCAN) begin
              scan_ack_o  <= 1'b1;
              scan_data_o <= mem_rdata_i;
            end else begin
              gfx_ack_o <= 1'b1;
              if (!mem_wr_o) begin
                gfx_data_o <= mem_rdata_i;
              end
            end
          end
        end
        DONE: begin
          gfx_ack_o  <= 1'b0;
          scan_ack_o <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          mem_req_o  <= 1'b0;
          gfx_ack_o  <= 1'b0;
          scan_ack_o <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vector table, swap/reset
// sequences, randomized single transactions and a contended request stream.
module tb_vram_arbiter;

  localparam logic [31:0] FB0 = 32'h0000_0000;
  localparam logic [31:0] FB1 = 32'h0000_4000;

  logic        clk;
  logic        reset_i;
  logic        gfx_sel_i;
  logic        gfx_wr_i;
  logic [3:0]  gfx_mask_i;
  logic [31:0] gfx_addr_i;
  logic [15:0] gfx_data_i;
  logic [15:0] gfx_data_o;
  logic        gfx_ack_o;
  logic        swap_i;
  logic        scan_req_i;
  logic [31:0] scan_addr_i;
  logic [15:0] scan_data_o;
  logic        scan_ack_o;
  logic        mem_req_o;
  logic        mem_wr_o;
  logic [3:0]  mem_mask_o;
  logic [31:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        front_o;

  vram_arbiter dut (
    .clk(clk), .reset_i(reset_i),
    .gfx_sel_i(gfx_sel_i), .gfx_wr_i(gfx_wr_i), .gfx_mask_i(gfx_mask_i),
    .gfx_addr_i(gfx_addr_i), .gfx_data_i(gfx_data_i), .gfx_data_o(gfx_data_o),
    .gfx_ack_o(gfx_ack_o), .swap_i(swap_i),
    .scan_req_i(scan_req_i), .scan_addr_i(scan_addr_i), .scan_data_o(scan_data_o),
    .scan_ack_o(scan_ack_o),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_mask_o(mem_mask_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .front_o(front_o)
  );

  int          total = 0;
  int          bad = 0;
  int          mem_lat = 1;
  bit          front_model = 1'b0;
  logic [15:0] gfx_hold = 16'h0000;
  logic [15:0] scan_hold = 16'h0000;
  logic [15:0] vmem [logic [31:0]];
  logic [31:0] last_addr = 32'h0;
  logic        last_wr = 1'b0;
  logic [3:0]  last_mask = 4'h0;
  logic [15:0] last_wdata = 16'h0;

  typedef struct {
    bit          g;
    bit          wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [15:0] wd;
    int          lat;
    bit          swap;
    bit          pre;
    logic [15:0] pdata;
    logic [31:0] eaddr;
    logic [15:0] edata;
    bit          efront;
  } vec_t;

  vec_t vt [11];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want run completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] mem_read(input logic [31:0] a);
    if (vmem.exists(a)) return vmem[a];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] apply_mask(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [3:0] m);
    logic [15:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*4 +: 4] = new_v[i*4 +: 4];
    return r;
  endfunction

  // Buffer model: scanout reads front, rasterizer uses the other; 32-bit wrap.
  function automatic logic [31:0] map_model(input bit g, input logic [31:0] a);
    logic [31:0] base;
    if (g) base = front_model ? FB0 : FB1;
    else   base = front_model ? FB1 : FB0;
    return base + a;
  endfunction

  // Behavioural VRAM: acks mem_lat cycles after the request is seen.
  initial begin
    int mcnt;
    mcnt = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = 16'h0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        mem_ack_i = 1'b0;
        mcnt = 0;
      end else if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        mcnt = 0;
      end else if (mem_req_o) begin
        mcnt++;
        if (mcnt >= mem_lat) begin
          last_addr = mem_addr_o;
          last_wr = mem_wr_o;
          last_mask = mem_mask_o;
          last_wdata = mem_wdata_o;
          if (mem_wr_o) vmem[mem_addr_o] = apply_mask(mem_read(mem_addr_o), mem_wdata_o, mem_mask_o);
          else mem_rdata_i = mem_read(mem_addr_o);
          mem_ack_i = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic pulse_swap();
    @(negedge clk); swap_i = 1'b1;
    @(negedge clk); swap_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // One isolated transaction; s1/s2 are cycle offsets for swap pulses (0 = none).
  task automatic single(input bit g, input bit wr, input logic [3:0] mask,
                        input logic [31:0] addr, input logic [15:0] wd, input int lat,
                        input int s1, input int s2, input logic [31:0] ea,
                        input logic [15:0] ed, input string nm);
    bit got, other;
    got = 1'b0;
    other = 1'b0;
    @(negedge clk);
    mem_lat = lat;
    if (g) begin
      gfx_wr_i = wr; gfx_mask_i = mask; gfx_addr_i = addr; gfx_data_i = wd; gfx_sel_i = 1'b1;
    end else begin
      scan_addr_i = addr; scan_req_i = 1'b1;
    end
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      swap_i = (c == s1) || (c == s2);
      if (g ? scan_ack_o : gfx_ack_o) other = 1'b1;
      if (g ? gfx_ack_o : scan_ack_o) got = 1'b1;
    end
    swap_i = 1'b0;
    gfx_sel_i = 1'b0;
    scan_req_i = 1'b0;
    chk({nm, "_ack"}, got, 1'b1);
    if (got) begin
      chk({nm, "_addr"}, last_addr, ea);
      chk({nm, "_wr"}, last_wr, g & wr);
      chk({nm, "_mask"}, last_mask, g ? mask : 4'h0);
      if (g && wr) chk({nm, "_wdata"}, last_wdata, wd);
      chk({nm, "_data"}, g ? gfx_data_o : scan_data_o, ed);
      chk({nm, "_front"}, front_o, front_model);
    end
    @(negedge clk);
    chk({nm, "_pulse"}, g ? gfx_ack_o : scan_ack_o, 1'b0);
    chk({nm, "_other"}, other, 1'b0);
    chk({nm, "_req"}, mem_req_o, 1'b0);
    if (!(g && wr)) begin
      if (g) gfx_hold = ed;
      else scan_hold = ed;
    end
  endtask

  task automatic new_gfx();
    gfx_wr_i = 1'($urandom_range(0, 1));
    gfx_mask_i = 4'($urandom);
    gfx_addr_i = 32'($urandom_range(0, 16383));
    gfx_data_i = 16'($urandom);
  endtask

  // Both masters keep requesting: service order must be 4 scans then 1 gfx.
  task automatic run_stream(input int n);
    int k;
    bit g_up, s_up, exp_g;
    logic [31:0] ea;
    logic [15:0] ed;
    k = 0; g_up = 1'b0; s_up = 1'b0;
    @(negedge clk);
    mem_lat = $urandom_range(1, 3);
    new_gfx();
    scan_addr_i = 32'($urandom_range(0, 16383));
    gfx_sel_i = 1'b1;
    scan_req_i = 1'b1;
    for (int c = 0; c < 3000 && k < n; c++) begin
      @(negedge clk);
      if (g_up) begin gfx_sel_i = 1'b1; g_up = 1'b0; end
      if (s_up) begin scan_req_i = 1'b1; s_up = 1'b0; end
      if (gfx_ack_o || scan_ack_o) begin
        exp_g = (k % 5) == 4;
        chk("stream_who", gfx_ack_o, exp_g);
        chk("stream_single_ack", gfx_ack_o & scan_ack_o, 1'b0);
        if (gfx_ack_o) begin
          ea = map_model(1'b1, gfx_addr_i);
          chk("stream_gaddr", last_addr, ea);
          chk("stream_gwr", last_wr, gfx_wr_i);
          chk("stream_gmask", last_mask, gfx_mask_i);
          if (gfx_wr_i) chk("stream_gwdata", last_wdata, gfx_data_i);
          ed = gfx_wr_i ? gfx_hold : mem_read(ea);
          chk("stream_gdata", gfx_data_o, ed);
          gfx_hold = ed;
          gfx_sel_i = 1'b0; g_up = 1'b1;
          new_gfx();
        end else begin
          ea = map_model(1'b0, scan_addr_i);
          chk("stream_saddr", last_addr, ea);
          chk("stream_swr", last_wr, 1'b0);
          ed = mem_read(ea);
          chk("stream_sdata", scan_data_o, ed);
          scan_hold = ed;
          scan_req_i = 1'b0; s_up = 1'b1;
          scan_addr_i = 32'($urandom_range(0, 16383));
        end
        mem_lat = $urandom_range(1, 3);
        k++;
      end
    end
    chk("stream_count", k, n);
    gfx_sel_i = 1'b0;
    scan_req_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit g, wr, seen;
    logic [3:0] mk;
    logic [31:0] ad, ea;
    logic [15:0] wd, ed;

    //            g    wr   mask  addr           wd       lat swp pre pdata    eaddr          edata    front
    vt[0]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0010, 16'hBEEF, 2, 1'b0, 1'b0, 16'h0000, 32'h0000_4010, 16'h0000, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0005, 16'h0000, 1, 1'b0, 1'b1, 16'h1234, 32'h0000_0005, 16'h1234, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 16'h0000, 1, 1'b0, 1'b0, 16'h0000, 32'h0000_4010, 16'hBEEF, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 4'h3, 32'h0000_0020, 16'hABCD, 3, 1'b0, 1'b0, 16'h0000, 32'h0000_4020, 16'hBEEF, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0020, 16'h0000, 1, 1'b0, 1'b0, 16'h0000, 32'h0000_4020, 16'h1ACD, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 4'hF, 32'hFFFF_C001, 16'h0F0F, 1, 1'b0, 1'b0, 16'h0000, 32'h0000_0001, 16'h1ACD, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0001, 16'h0000, 2, 1'b0, 1'b0, 16'h0000, 32'h0000_0001, 16'h0F0F, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 16'h0000, 1, 1'b1, 1'b1, 16'h7777, 32'h0000_4000, 16'h7777, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 16'h0000, 1, 1'b0, 1'b0, 16'h0000, 32'h0000_0010, 16'h5A4A, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 4'h0, 32'hFFFF_C005, 16'h0000, 4, 1'b0, 1'b0, 16'h0000, 32'h0000_0005, 16'h1234, 1'b1};
    vt[10] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 16'h0000, 1, 1'b1, 1'b0, 16'h0000, 32'h0000_0010, 16'h5A4A, 1'b0};

    reset_i = 1'b1; gfx_sel_i = 1'b0; gfx_wr_i = 1'b0; gfx_mask_i = 4'h0;
    gfx_addr_i = 32'h0; gfx_data_i = 16'h0; swap_i = 1'b0;
    scan_req_i = 1'b0; scan_addr_i = 32'h0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_wr", mem_wr_o, 1'b0);
    chk("rst_mem_mask", mem_mask_o, 4'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 16'h0);
    chk("rst_acks", {gfx_ack_o, scan_ack_o}, 2'b00);
    chk("rst_data", {gfx_data_o, scan_data_o}, 32'h0);
    chk("rst_front", front_o, 1'b0);

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      if (vt[i].swap) begin
        pulse_swap();
        front_model = vt[i].efront;
        chk($sformatf("vec%0d_swapfront", i), front_o, vt[i].efront);
      end
      if (vt[i].pre) vmem[vt[i].eaddr] = vt[i].pdata;
      single(vt[i].g, vt[i].wr, vt[i].mask, vt[i].addr, vt[i].wd, vt[i].lat, 0, 0,
             vt[i].eaddr, vt[i].edata, $sformatf("vec%0d", i));
    end

    // Swap while a gfx write is in flight: old back buffer used, front flips afterwards.
    single(1'b1, 1'b1, 4'hF, 32'h30, 16'h1111, 5, 2, 0, 32'h0000_4030, gfx_hold, "swap_busy");
    front_model = 1'b1;
    @(negedge clk);
    chk("swap_busy_front", front_o, 1'b1);
    single(1'b0, 1'b0, 4'h0, 32'h0, 16'h0, 1, 0, 0, 32'h0000_4000, 16'h7777, "scan_after_swap");

    // Two swap pulses inside one transaction cancel out.
    ea = map_model(1'b1, 32'h40);
    single(1'b1, 1'b0, 4'h0, 32'h40, 16'h0, 6, 2, 4, ea, mem_read(ea), "dbl_swap");
    repeat (2) @(negedge clk);
    chk("dbl_swap_front", front_o, 1'b1);

    // Randomized isolated transactions against the buffer/memory model.
    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_swap();
        front_model = ~front_model;
        chk($sformatf("rnd%0d_swapfront", r), front_o, front_model);
      end
      g = 1'($urandom_range(0, 1));
      wr = g ? 1'($urandom_range(0, 1)) : 1'b0;
      mk = 4'($urandom);
      ad = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 16383));
      wd = 16'($urandom);
      ea = map_model(g, ad);
      ed = (g && wr) ? gfx_hold : mem_read(ea);
      single(g, wr, mk, ad, wd, $urandom_range(1, 4), 0, 0, ea, ed, $sformatf("rnd%0d", r));
    end

    // Reset while BUSY abandons the transaction without an ack.
    @(negedge clk);
    mem_lat = 8;
    gfx_wr_i = 1'b0; gfx_mask_i = 4'h0; gfx_addr_i = 32'h50; gfx_sel_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = mem_req_o;
    end
    chk("rstbusy_req_up", seen, 1'b1);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("rstbusy_req_drop", mem_req_o, 1'b0);
    chk("rstbusy_front", front_o, 1'b0);
    gfx_sel_i = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | gfx_ack_o | scan_ack_o; end
    reset_i = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | gfx_ack_o | scan_ack_o; end
    chk("rstbusy_no_ack", seen, 1'b0);
    chk("rstbusy_gdata", gfx_data_o, 16'h0);
    front_model = 1'b0;
    gfx_hold = 16'h0;
    scan_hold = 16'h0;
    ea = map_model(1'b1, 32'h50);
    single(1'b1, 1'b0, 4'h0, 32'h50, 16'h0, 1, 0, 0, ea, mem_read(ea), "post_rst");

    // Contended stream with starvation limit.
    run_stream(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
